// File: rtl/ladybird_alu_arb_pkg.sv
// Shared types and constants for the ladybird ALU arbiter.
package ladybird_alu_arb_pkg;

    localparam int ARB_XLEN = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    typedef struct packed {
        logic [2:0]          operation;
        logic                alternate;
        logic [ARB_XLEN-1:0] src1;
        logic [ARB_XLEN-1:0] src2;
    } alu_req_t;

endpackage

// File: rtl/ladybird_alu.sv
// Combinational RV32-style integer ALU selected by funct3, with ALTERNATE choosing SUB/SRA.
module ladybird_alu
    import ladybird_alu_arb_pkg::*;
#(
    parameter int XLEN       = ARB_XLEN,
    parameter int SIMULATION = 0
) (
    input  logic [2:0]      OPERATION,
    input  logic            ALTERNATE,
    input  logic [XLEN-1:0] SRC1,
    input  logic [XLEN-1:0] SRC2,
    output logic [XLEN-1:0] Q
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] w_shamt;
    assign w_shamt = SRC2[SH_W-1:0];

    always_comb begin
        Q = '0;
        case (OPERATION)
            OP_ADD:  Q = ALTERNATE ? (SRC1 - SRC2) : (SRC1 + SRC2);
            3'b001:  Q = SRC1 << w_shamt;
            OP_SLT:  Q = {{(XLEN-1){1'b0}}, ($signed(SRC1) < $signed(SRC2))};
            OP_SLTU: Q = {{(XLEN-1){1'b0}}, (SRC1 < SRC2)};
            OP_XOR:  Q = SRC1 ^ SRC2;
            3'b101:  Q = ALTERNATE ? XLEN'($signed(SRC1) >>> w_shamt) : (SRC1 >> w_shamt);
            3'b110:  Q = SRC1 | SRC2;
            default: Q = SRC1 & SRC2;
        endcase
    end

    // ALTERNATE only has a meaning for ADD/SUB and SRL/SRA.
    if (SIMULATION != 0) begin : g_sim_chk
        always_comb begin
            assert (!ALTERNATE || OPERATION == 3'b000 || OPERATION == 3'b101);
        end
    end

endmodule

// File: rtl/ladybird_alu_arbiter_rr_grant.sv
// ladybird_rr_grant: one-hot pick of the first request at or after i_ptr, wrapping modulo NREQ.
module ladybird_rr_grant #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant
);
    always_comb begin
        int idx;
        idx     = 0;
        o_grant = '0;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (i_req[idx]) o_grant = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: rtl/ladybird_alu_arbiter.sv
// Shares one ladybird_alu among NREQ valid/ready requesters with a single registered response.
// Define LADYBIRD_ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest) instead of round-robin.
module ladybird_alu_arbiter
    import ladybird_alu_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int XLEN       = ARB_XLEN,
    parameter int SIMULATION = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ*3-1:0] REQ_OPERATION,
    input  logic [NREQ-1:0]   REQ_ALTERNATE,
    input  logic [NREQ*XLEN-1:0] REQ_SRC1,
    input  logic [NREQ*XLEN-1:0] REQ_SRC2,
    output logic [NREQ-1:0]   RSP_VALID,
    input  logic [NREQ-1:0]   RSP_READY,
    output logic [XLEN-1:0]   RSP_Q,
    output logic              BUSY
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             r_vld_p0;
    logic [PTR_W-1:0] r_owner_p0;
    logic [XLEN-1:0]  r_rsp_q_p0;

    logic             w_can_accept;
    logic             w_accept;
    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_grant;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [2:0]       w_op;
    logic             w_alt;
    logic [XLEN-1:0]  w_src1;
    logic [XLEN-1:0]  w_src2;
    logic [XLEN-1:0]  w_alu_q;

    assign w_can_accept = !r_vld_p0 || RSP_READY[r_owner_p0];
    assign w_req        = REQ_VALID & {NREQ{w_can_accept & RESET_N}};
    assign w_accept     = |w_grant;
    assign REQ_READY    = w_grant;

    ladybird_rr_grant #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_grant (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gidx = '0;
        w_op   = '0;
        w_alt  = 1'b0;
        w_src1 = '0;
        w_src2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = PTR_W'(i);
                w_op   = REQ_OPERATION[i*3 +: 3];
                w_alt  = REQ_ALTERNATE[i];
                w_src1 = REQ_SRC1[i*XLEN +: XLEN];
                w_src2 = REQ_SRC2[i*XLEN +: XLEN];
            end
        end
    end

    assign w_ptr_next = (w_gidx == PTR_W'(NREQ - 1)) ? '0 : (w_gidx + 1'b1);

    ladybird_alu #(
        .XLEN       (XLEN),
        .SIMULATION (SIMULATION)
    ) u_alu (
        .OPERATION (w_op),
        .ALTERNATE (w_alt),
        .SRC1      (w_src1),
        .SRC2      (w_src2),
        .Q         (w_alu_q)
    );

`ifdef LADYBIRD_ALU_ARB_FIXED_PRIORITY_EN
    assign w_ptr = '0;
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_ptr_next;
`else
    logic [PTR_W-1:0] r_ptr;
    assign w_ptr = r_ptr;

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_ptr <= '0;
        else if (w_accept) r_ptr <= w_ptr_next;
    end
`endif

    // ---- stage p0: response register (drain and refill may happen in the same cycle) ----
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_vld_p0   <= 1'b0;
            r_owner_p0 <= '0;
            r_rsp_q_p0 <= '0;
        end else if (w_accept) begin
            r_vld_p0   <= 1'b1;
            r_owner_p0 <= w_gidx;
            r_rsp_q_p0 <= w_alu_q;
        end else if (r_vld_p0 && RSP_READY[r_owner_p0]) begin
            r_vld_p0   <= 1'b0;
        end
    end

    assign RSP_VALID = r_vld_p0 ? ({{(NREQ-1){1'b0}}, 1'b1} << r_owner_p0) : '0;
    assign RSP_Q     = r_rsp_q_p0;
    assign BUSY      = |RSP_VALID;

endmodule

// File: tb/tb_ladybird_alu_arbiter.sv
// Scoreboard bench for ladybird_alu_arbiter with two requesters and 32-bit operands.
module tb_ladybird_alu_arbiter;
    import ladybird_alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [1:0]  req_alt;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_q;
    logic        busy;

    typedef struct {
        logic [1:0]  own;
        logic [31:0] q;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ladybird_alu_arbiter #(
        .NREQ       (2),
        .XLEN       (32),
        .SIMULATION (0)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .REQ_VALID     (req_valid),
        .REQ_READY     (req_ready),
        .REQ_OPERATION (req_op),
        .REQ_ALTERNATE (req_alt),
        .REQ_SRC1      (req_src1),
        .REQ_SRC2      (req_src2),
        .RSP_VALID     (rsp_valid),
        .RSP_READY     (rsp_ready),
        .RSP_Q         (rsp_q),
        .BUSY          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic v, input alu_req_t r);
        req_valid[i]          = v;
        req_op[i*3 +: 3]      = r.operation;
        req_alt[i]            = r.alternate;
        req_src1[i*32 +: 32]  = r.src1;
        req_src2[i*32 +: 32]  = r.src2;
    endtask

    // One cycle: inputs already driven; check grant and response state, queue the accepted result.
    task automatic step(input logic [1:0] exp_rdy, input logic [1:0] exp_rspv, input logic [31:0] exp_q);
        exp_t e;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rspv));
        chk("busy", 32'(busy), 32'(|exp_rspv));
        if (exp_rdy != 2'b00) begin
            e.own = exp_rdy;
            e.q   = exp_q;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake pops the oldest expected result.
    always @(negedge clk) begin
        if ((rsp_valid & rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got valid=%b q=%h, required no response", rsp_valid, rsp_q);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_owner", 32'(rsp_valid), 32'(mon_e.own));
                chk("rsp_q", rsp_q, mon_e.q);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] CQ [6] = '{32'hF0F0FFFF, 32'h65, 32'hF0F0FFFD, 32'h67, 32'hF0F0FFFB, 32'h69};
    localparam logic [1:0]  CR [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    localparam logic [1:0]  CV [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b00;
        req_op    = '0;
        req_alt   = '0;
        req_src1  = '0;
        req_src2  = '0;
        set_req(0, 1'b1, '{OP_ADD, 1'b0, 32'h66666667, 32'h66666667});
        set_req(1, 1'b1, '{OP_ADD, 1'b1, 32'd5, 32'd3});
        @(posedge clk);
        #1;

        // Reset held with all requests valid
        for (int i = 0; i < 3; i++) begin
            chk("rsp_q_rst", rsp_q, 32'h0);
            step(2'b00, 2'b00, 32'h0);
        end

        rst_n = 1'b1;
        step(2'b01, 2'b00, 32'hCCCCCCCE);

`ifdef LADYBIRD_ALU_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, '{OP_ADD, 1'b0, 32'(i), 32'd100});
            step(2'b01, 2'b01, 32'd100 + 32'(i));
        end
        req_valid = 2'b00;
        step(2'b00, 2'b01, 32'h0);
        step(2'b00, 2'b00, 32'h0);
`else
        // SUB then SLT with a negative operand
        set_req(0, 1'b1, '{OP_SLT, 1'b0, 32'hFFFFFDFF, 32'd5});
        step(2'b10, 2'b01, 32'd2);
        req_valid = 2'b01;
        step(2'b01, 2'b10, 32'd1);
        req_valid = 2'b00;
        step(2'b00, 2'b01, 32'h0);
        step(2'b00, 2'b00, 32'h0);

        // Contention: alternating grants, back-to-back responses
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, '{OP_ADD, 1'b0, 32'(i), 32'd100});
            set_req(1, 1'b1, '{OP_XOR, 1'b0, 32'hF0F00000 | 32'(i), 32'h0000FFFF});
            step(CR[i], CV[i], CQ[i]);
        end

        // Backpressure on owner 0
        set_req(0, 1'b1, '{OP_ADD, 1'b0, 32'h7FFFFFFF, 32'h1});
        set_req(1, 1'b1, '{OP_XOR, 1'b0, 32'h12345678, 32'hFFFFFFFF});
        rsp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 2'b01, 32'h0);
            chk("rsp_q_hold", rsp_q, 32'h69);
        end
        rsp_ready = 2'b11;
        step(2'b10, 2'b01, 32'hEDCBA987);
        step(2'b01, 2'b10, 32'h80000000);

        // Reset while FULL and stalled: response discarded, pointer back to 0
        rsp_ready = 2'b00;
        step(2'b00, 2'b01, 32'h0);
        rst_n = 1'b0;
        step(2'b00, 2'b01, 32'h0);
        sb.delete();
        chk("rsp_q_mid_rst", rsp_q, 32'h0);
        rst_n     = 1'b1;
        rsp_ready = 2'b11;
        set_req(0, 1'b1, '{OP_SLTU, 1'b0, 32'h1, 32'hFFFFFFFF});
        step(2'b01, 2'b00, 32'h1);
        req_valid = 2'b00;
        step(2'b00, 2'b01, 32'h0);
        step(2'b00, 2'b00, 32'h0);
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
